// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared definitions for the bit-serial adder controller.
// Holds the controller state encoding used by serial_add_ctrl.
package serial_add_pkg;

  // Controller states: waiting for a request, or stepping bits through the cell.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// FA: single-bit full-adder cell.
// Purely combinational; the serial controller reuses one instance for every bit.
module FA (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  logic p;

  assign p    = A ^ B;
  assign S    = p ^ Cin;
  assign Cout = (A & B) | (Cin & p);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// Adds two WIDTH-bit operands LSB-first through one FA cell over WIDTH cycles,
// then reports sum, carry-out and signed overflow with a one-cycle done pulse.
// Optional macro SERIAL_ADD_SUB_EN adds a Sub input that turns the operation
// into A - B (B inverted, carry-in forced to 1).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             Sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  // Bit counter just wide enough to hold WIDTH.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_chk
    $error("serial_add_ctrl: WIDTH must be at least 2");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] s_next;

  // Operand conditioning at capture time: subtraction is A + ~B + 1.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load = Sub ? ~B : B;
  assign c_load = Sub | Cin;
`else
  assign b_load = B;
  assign c_load = Cin;
`endif

  // The one shared adder cell always looks at the current LSBs and carry.
  FA u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_c)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
  assign s_next = {fa_s, s_sh[WIDTH-1:1]};

  // Controller FSM with registered datapath and outputs; reset discards any run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      S       <= '0;
      Cout    <= 1'b0;
      V       <= 1'b0;
      cnt     <= '0;
      carry_q <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          // done is a single-cycle pulse; a start on the done cycle is accepted.
          done <= 1'b0;
          if (start) begin
            a_sh    <= A;
            b_sh    <= b_load;
            carry_q <= c_load;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end
        end

        ST_RUN: begin
          // start and operand inputs are ignored here; only latched copies move.
          s_sh    <= s_next;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry_q <= fa_c;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            // carry_q is the carry into the MSB here, fa_c the carry out of it.
            S     <= s_next;
            Cout  <= fa_c;
            V     <= carry_q ^ fa_c;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
